// File: rtl/rf_pkg.sv
// Shared sizing and types for the 8 x 16 general-purpose register file.
package rf_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] rf_word_t;
   typedef logic [ADDR_W-1:0] rf_idx_t;

endpackage : rf_pkg

// File: rtl/reg_file_decoder.sv
// Binary-to-one-hot decoder with enable; an unknown index decodes to no output.
module reg_file_decoder #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 2 ** IN_W
) (
   input  logic [IN_W-1:0]  idx_i,
   input  logic             en_i,
   output logic [OUT_W-1:0] onehot_o
);

   always_comb begin
      // NOTE: assign the whole output first so every path drives it and no latch is inferred.
      onehot_o = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (en_i && (idx_i == IN_W'(i))) begin
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule : reg_file_decoder

// File: rtl/reg_file.sv
// Register file: one synchronous write port, one combinational read port, async clear.
module reg_file
   import rf_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  rf_word_t data_in,
   input  rf_idx_t  writenum,
   input  logic     write,
   input  rf_idx_t  readnum,
   output rf_word_t data_out
);

   logic [NUM_REGS-1:0] load;
   rf_word_t            regs_q [NUM_REGS];
   rf_word_t            regs_d [NUM_REGS];

   reg_file_decoder #(
      .IN_W  (ADDR_W),
      .OUT_W (NUM_REGS)
   ) u_wr_dec (
      .idx_i    (writenum),
      .en_i     (write),
      .onehot_o (load)
   );

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      assign regs_d[g] = load[g] ? data_in : regs_q[g];

      // NOTE: every register is cleared on reset because software relies on reading zero afterwards.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            regs_q[g] <= '0;
         end else begin
            // NOTE: non-blocking so all flops sample pre-edge values, matching hardware.
            regs_q[g] <= regs_d[g];
         end
      end
   end

   // No write bypass: a same-cycle write becomes visible only after the edge.
   always_comb begin
      data_out = regs_q[readnum];
   end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: reads push expectations, a monitor pops and compares.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] data_in = '0;
   logic [2:0]  writenum = '0;
   logic        write = 1'b0;
   logic [2:0]  readnum = '0;
   logic [15:0] data_out;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] model [8];
   int          checks = 0;
   int          errors = 0;
   event        rd_ev;

   reg_file dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .writenum (writenum),
      .write    (write),
      .readnum  (readnum),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   // Monitor: each read strobe presents one output word to compare.
   initial begin
      exp_t e;
      forever begin
         @(rd_ev);
         #1;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read actual=%h required=<no expectation>", data_out);
         end else begin
            e = sb_q.pop_front();
            if (data_out !== e.exp) begin
               errors++;
               $display("FAIL %s actual=%h required=%h", e.name, data_out, e.exp);
            end
         end
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
   endtask

   task automatic read_check(input string name, input logic [2:0] idx);
      exp_t e;
      readnum = idx;
      e.name  = name;
      e.exp   = model[idx];
      sb_q.push_back(e);
      ->rd_ev;
      #2;
   endtask

   task automatic do_write(input logic [2:0] wn, input logic [15:0] d, input logic we);
      @(negedge clk);
      writenum = wn;
      data_in  = d;
      write    = we;
      @(posedge clk);
      if (we && !reset) model[wn] = d;
      #1;
      write = 1'b0;
   endtask

   initial begin
      logic [2:0]  wn;
      logic [15:0] d;
      logic        we;

      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Write some values, then reset mid-cycle with no clock edge.
      do_write(3'd2, 16'h5555, 1'b1);
      do_write(3'd6, 16'h6666, 1'b1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      clear_model();
      #1;
      for (int i = 0; i < 8; i++) read_check($sformatf("reset_r%0d", i), 3'(i));
      @(negedge clk);
      reset = 1'b0;

      // MOV R3, #42 and sequential writes.
      do_write(3'd3, 16'h002A, 1'b1);
      read_check("mov_r3", 3'd3);
      do_write(3'd0, 16'h0007, 1'b1);
      do_write(3'd1, 16'h0002, 1'b1);
      read_check("seq_r0", 3'd0);
      read_check("seq_r1", 3'd1);
      read_check("seq_r3", 3'd3);

      // Write disabled: R3 must hold.
      do_write(3'd3, 16'hFFFF, 1'b0);
      read_check("wr_disable_r3", 3'd3);

      // Read-during-write on R5: old value before the edge, new value after.
      do_write(3'd5, 16'h1234, 1'b1);
      @(negedge clk);
      writenum = 3'd5;
      data_in  = 16'hBEEF;
      write    = 1'b1;
      read_check("rdw_before", 3'd5);
      @(posedge clk);
      model[5] = 16'hBEEF;
      #1;
      write = 1'b0;
      read_check("rdw_after", 3'd5);

      // Full sweep for aliasing.
      for (int i = 0; i < 8; i++) do_write(3'(i), 16'hA000 + 16'(i), 1'b1);
      for (int i = 0; i < 8; i++) read_check($sformatf("sweep_r%0d", i), 3'(i));

      // Randomized traffic against the array model.
      for (int n = 0; n < 150; n++) begin
         wn = 3'($urandom_range(0, 7));
         d  = 16'($urandom);
         we = 1'($urandom_range(0, 3) != 0);
         do_write(wn, d, we);
         read_check("rand_read", 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 4) == 0) read_check("rand_wr_target", wn);
      end

      // Asynchronous reset pulse between edges clears everything.
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      clear_model();
      for (int i = 0; i < 8; i++) read_check($sformatf("final_reset_r%0d", i), 3'(i));

      #5;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_file
